// File: rtl/tank_pkg.sv
// Shared constants and types for the tank game datapath: screen limits, keycodes,
// fixed-point format and the per-shell state record.
package tank_pkg;

  localparam int X_MAX  = 639;
  localparam int Y_MAX  = 479;
  localparam int FRAC_W = 4;
  localparam int POS_W  = 10 + FRAC_W;  // 10.4 unsigned position
  localparam int VEL_W  = 12;           // signed velocity in 1/16 pixel per frame
  localparam int AGE_W  = 9;

  localparam logic [7:0] FIRE_KEY  = 8'h2C;
  localparam logic [7:0] KEY_RIGHT = 8'h4F;
  localparam logic [7:0] KEY_LEFT  = 8'h50;
  localparam logic [7:0] KEY_DOWN  = 8'h51;
  localparam logic [7:0] KEY_UP    = 8'h52;

  typedef struct packed {
    logic                    active;
    logic [POS_W-1:0]        pos_x;
    logic [POS_W-1:0]        pos_y;
    logic signed [VEL_W-1:0] dx;
    logic signed [VEL_W-1:0] dy;
    logic [AGE_W-1:0]        age;
  } shell_state_t;

  // True when any of the four packed keycode bytes equals key.
  function automatic logic key_match(input logic [31:0] kc, input logic [7:0] key);
    logic hit;
    hit = 1'b0;
    for (int b = 0; b < 4; b++) hit |= (kc[8*b +: 8] == key);
    return hit;
  endfunction

endpackage

// File: rtl/tank_shell_slot.sv
// One shell slot: straight-line motion, edge reflection and lifetime expiry.
// With TANK_SHELL_BOUNCE_LIMIT_EN defined the slot also dies on its 5th reflecting frame.
module tank_shell_slot
  import tank_pkg::*;
#(
  parameter int LIFETIME = 300
) (
  input  logic                    frame_clk,
  input  logic                    Reset,
  input  logic                    load,
  input  logic [9:0]              load_x,
  input  logic [9:0]              load_y,
  input  logic signed [VEL_W-1:0] load_dx,
  input  logic signed [VEL_W-1:0] load_dy,
  output logic                    active,
  output logic [9:0]              shell_x,
  output logic [9:0]              shell_y
);

  shell_state_t   state_q, state_d;
  logic [POS_W:0] nx, ny;
  logic           hit_x, hit_y;
`ifdef TANK_SHELL_BOUNCE_LIMIT_EN
  logic [2:0]     bounce_q, bounce_d;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
`ifdef TANK_SHELL_BOUNCE_LIMIT_EN
    bounce_d = bounce_q;
`endif
    // One extra bit holds the sign: a negative sum means the shell crossed the 0 edge.
    nx    = {1'b0, state_q.pos_x} + {{(POS_W+1-VEL_W){state_q.dx[VEL_W-1]}}, state_q.dx};
    ny    = {1'b0, state_q.pos_y} + {{(POS_W+1-VEL_W){state_q.dy[VEL_W-1]}}, state_q.dy};
    hit_x = nx[POS_W] || (nx[POS_W-1:FRAC_W] > 10'(X_MAX));
    hit_y = ny[POS_W] || (ny[POS_W-1:FRAC_W] > 10'(Y_MAX));

    if (load) begin
      state_d.active = 1'b1;
      state_d.pos_x  = {load_x, {FRAC_W{1'b0}}};
      state_d.pos_y  = {load_y, {FRAC_W{1'b0}}};
      state_d.dx     = load_dx;
      state_d.dy     = load_dy;
      state_d.age    = AGE_W'(LIFETIME);
`ifdef TANK_SHELL_BOUNCE_LIMIT_EN
      bounce_d       = '0;
`endif
    end else if (state_q.active) begin
      if (state_q.age == AGE_W'(1)) begin
        state_d.active = 1'b0;
      end else begin
        state_d.age = state_q.age - AGE_W'(1);
        if (hit_x) state_d.dx = -state_q.dx;
        else       state_d.pos_x = nx[POS_W-1:0];
        if (hit_y) state_d.dy = -state_q.dy;
        else       state_d.pos_y = ny[POS_W-1:0];
`ifdef TANK_SHELL_BOUNCE_LIMIT_EN
        // A corner hit reflects both axes but counts as a single bounce.
        if (hit_x || hit_y) begin
          if (bounce_q == 3'd4) state_d.active = 1'b0;
          else                  bounce_d = bounce_q + 3'd1;
        end
`endif
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= '0;
`ifdef TANK_SHELL_BOUNCE_LIMIT_EN
      bounce_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
`ifdef TANK_SHELL_BOUNCE_LIMIT_EN
      bounce_q <= bounce_d;
`endif
    end
  end

  assign active  = state_q.active;
  assign shell_x = state_q.pos_x[POS_W-1:FRAC_W];
  assign shell_y = state_q.pos_y[POS_W-1:FRAC_W];

endmodule

// File: rtl/tank_shell_ctrl.sv
// Shell spawner: fire-key edge detect, spawn cooldown and lowest-free-slot selection
// over NUM_SHELLS slots. Optional feature macro: TANK_SHELL_BOUNCE_LIMIT_EN.
module tank_shell_ctrl
  import tank_pkg::*;
#(
  parameter int NUM_SHELLS = 4,
  parameter int LIFETIME   = 300,
  parameter int COOLDOWN   = 15,
  parameter int SPEED      = 4
) (
  input  logic                    frame_clk,
  input  logic                    Reset,
  input  logic [31:0]             keycode,
  input  logic [9:0]              TankX,
  input  logic [9:0]              TankY,
  input  logic [5:0]              Angle,
  input  logic [7:0]              sin,
  input  logic [7:0]              cos,
  output logic [10*NUM_SHELLS-1:0] ShellX,
  output logic [10*NUM_SHELLS-1:0] ShellY,
  output logic [NUM_SHELLS-1:0]   ShellActive,
  output logic                    Fired
);

  localparam int CD_W = $clog2(COOLDOWN + 1);

  logic                    fire_now, press, found, spawn;
  logic                    fire_prev_q, fire_prev_d;
  logic                    fired_q, fired_d;
  logic [CD_W-1:0]         cooldown_q, cooldown_d;
  logic [NUM_SHELLS-1:0]   sel_vec, load_vec, active_vec;
  logic signed [VEL_W-1:0] cos_ext, sin_ext, spd_cos, spd_sin, spawn_dx, spawn_dy;

  // Heading reaches this block already resolved through sin/cos.
  logic unused_angle;
  assign unused_angle = ^Angle;

  always_comb begin
    fire_now    = key_match(keycode, FIRE_KEY);
    press       = fire_now & ~fire_prev_q;
    fire_prev_d = fire_now;

    // Free slots come from the registered active flags, so a slot expiring on this
    // edge cannot be reused until the next one.
    sel_vec = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_SHELLS; i++) begin
      if (!active_vec[i] && !found) begin
        sel_vec[i] = 1'b1;
        found      = 1'b1;
      end
    end

    spawn    = press && (cooldown_q == '0) && found;
    load_vec = spawn ? sel_vec : '0;
    fired_d  = spawn;

    if (spawn)                 cooldown_d = CD_W'(COOLDOWN);
    else if (cooldown_q != '0) cooldown_d = cooldown_q - CD_W'(1);
    else                       cooldown_d = cooldown_q;

    cos_ext  = {{(VEL_W-8){cos[7]}}, cos};
    sin_ext  = {{(VEL_W-8){sin[7]}}, sin};
    spd_cos  = cos_ext * VEL_W'(SPEED);
    spd_sin  = sin_ext * VEL_W'(SPEED);
    spawn_dx = spd_cos >>> 3;
    spawn_dy = -(spd_sin >>> 3);  // screen Y grows downward
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      fire_prev_q <= 1'b0;
      fired_q     <= 1'b0;
      cooldown_q  <= '0;
    end else begin
      fire_prev_q <= fire_prev_d;
      fired_q     <= fired_d;
      cooldown_q  <= cooldown_d;
    end
  end

  for (genvar g = 0; g < NUM_SHELLS; g++) begin : g_slot
    tank_shell_slot #(
      .LIFETIME(LIFETIME)
    ) u_slot (
      .frame_clk(frame_clk),
      .Reset    (Reset),
      .load     (load_vec[g]),
      .load_x   (TankX),
      .load_y   (TankY),
      .load_dx  (spawn_dx),
      .load_dy  (spawn_dy),
      .active   (active_vec[g]),
      .shell_x  (ShellX[10*g +: 10]),
      .shell_y  (ShellY[10*g +: 10])
    );
  end

  assign ShellActive = active_vec;
  assign Fired       = fired_q;

endmodule

// File: tb/tb_tank_shell_ctrl.sv
// Directed bench for tank_shell_ctrl: a per-frame vector table for spawn, motion and
// wall reflection, then hand-written sequences for cooldown, slot exhaustion, expiry and reset.
module tb_tank_shell_ctrl;

`ifdef TANK_SHELL_BOUNCE_LIMIT_EN
  localparam int LIFE = 500;  // long enough for five wall bounces to come first
`else
  localparam int LIFE = 300;
`endif
  localparam logic [31:0] FK = 32'h0000_002C;

  logic        frame_clk, Reset;
  logic [31:0] keycode;
  logic [9:0]  TankX, TankY;
  logic [5:0]  Angle;
  logic [7:0]  sin, cos;
  logic [39:0] ShellX, ShellY;
  logic [3:0]  ShellActive;
  logic        Fired;

  int n_cmp = 0;
  int n_err = 0;

  tank_shell_ctrl #(.LIFETIME(LIFE)) dut (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .keycode    (keycode),
    .TankX      (TankX),
    .TankY      (TankY),
    .Angle      (Angle),
    .sin        (sin),
    .cos        (cos),
    .ShellX     (ShellX),
    .ShellY     (ShellY),
    .ShellActive(ShellActive),
    .Fired      (Fired)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  typedef struct {
    bit          rst;
    logic [31:0] key;
    logic [9:0]  tx, ty;
    logic [7:0]  s, c;
    logic [3:0]  act;
    bit          fired;
    logic [9:0]  x, y;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic [31:0] k);
    keycode = k;
    @(posedge frame_clk);
    #1;
  endtask

  task automatic do_reset();
    keycode = '0;
    Reset   = 1'b1;
    @(posedge frame_clk);
    #1;
    Reset   = 1'b0;
  endtask

  function automatic logic [9:0] sx(input int i);
    return ShellX[10*i +: 10];
  endfunction

  function automatic logic [9:0] sy(input int i);
    return ShellY[10*i +: 10];
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fire_cnt;
    Reset = 1'b1; keycode = '0; TankX = '0; TankY = '0; Angle = '0; sin = '0; cos = '0;
    #2;
    check("rst_active", ShellActive, 4'b0000);
    check("rst_fired",  Fired, 1'b0);
    check("rst_x",      ShellX, 40'd0);
    check("rst_y",      ShellY, 40'd0);
    @(posedge frame_clk); #1;
    Reset = 1'b0;

    // rst, key, tx, ty, sin, cos -> active, fired, slot0 x, slot0 y
    vq.push_back('{1, 32'h4F50_5152, 10'd300, 10'd250, 8'h00, 8'h7F, 4'b0000, 0, 10'd0,   10'd0});
    vq.push_back('{0, FK,            10'd300, 10'd250, 8'h00, 8'h7F, 4'b0001, 1, 10'd300, 10'd250});
    vq.push_back('{0, 32'h0,         10'd300, 10'd250, 8'h00, 8'h7F, 4'b0001, 0, 10'd303, 10'd250});
    vq.push_back('{0, 32'h0,         10'd300, 10'd250, 8'h00, 8'h7F, 4'b0001, 0, 10'd307, 10'd250});
    vq.push_back('{0, 32'h0,         10'd300, 10'd250, 8'h00, 8'h7F, 4'b0001, 0, 10'd311, 10'd250});
    vq.push_back('{1, 32'h002C_0000, 10'd100, 10'd200, 8'h7F, 8'h00, 4'b0001, 1, 10'd100, 10'd200});
    vq.push_back('{0, 32'h0,         10'd100, 10'd200, 8'h7F, 8'h00, 4'b0001, 0, 10'd100, 10'd196});
    vq.push_back('{0, 32'h0,         10'd100, 10'd200, 8'h7F, 8'h00, 4'b0001, 0, 10'd100, 10'd192});
    vq.push_back('{0, 32'h0,         10'd100, 10'd200, 8'h7F, 8'h00, 4'b0001, 0, 10'd100, 10'd188});
    vq.push_back('{1, 32'h2C00_0000, 10'd50,  10'd60,  8'h00, 8'h80, 4'b0001, 1, 10'd50,  10'd60});
    vq.push_back('{0, 32'h0,         10'd50,  10'd60,  8'h00, 8'h80, 4'b0001, 0, 10'd46,  10'd60});
    vq.push_back('{0, 32'h0,         10'd50,  10'd60,  8'h00, 8'h80, 4'b0001, 0, 10'd42,  10'd60});
    vq.push_back('{1, FK,            10'd637, 10'd1,   8'h7F, 8'h7F, 4'b0001, 1, 10'd637, 10'd1});
    vq.push_back('{0, 32'h0,         10'd637, 10'd1,   8'h7F, 8'h7F, 4'b0001, 0, 10'd637, 10'd1});
    vq.push_back('{0, 32'h0,         10'd637, 10'd1,   8'h7F, 8'h7F, 4'b0001, 0, 10'd633, 10'd4});
    vq.push_back('{0, 32'h0,         10'd637, 10'd1,   8'h7F, 8'h7F, 4'b0001, 0, 10'd629, 10'd8});
    vq.push_back('{1, FK,            10'd637, 10'd477, 8'h81, 8'h7F, 4'b0001, 1, 10'd637, 10'd477});
    vq.push_back('{0, 32'h0,         10'd637, 10'd477, 8'h81, 8'h7F, 4'b0001, 0, 10'd637, 10'd477});
    vq.push_back('{0, 32'h0,         10'd637, 10'd477, 8'h81, 8'h7F, 4'b0001, 0, 10'd633, 10'd473});
    vq.push_back('{1, FK,            10'd2,   10'd5,   8'h00, 8'h80, 4'b0001, 1, 10'd2,   10'd5});
    vq.push_back('{0, 32'h0,         10'd2,   10'd5,   8'h00, 8'h80, 4'b0001, 0, 10'd2,   10'd5});
    vq.push_back('{0, 32'h0,         10'd2,   10'd5,   8'h00, 8'h80, 4'b0001, 0, 10'd6,   10'd5});

    foreach (vq[i]) begin
      if (vq[i].rst) do_reset();
      TankX = vq[i].tx; TankY = vq[i].ty; sin = vq[i].s; cos = vq[i].c;
      step(vq[i].key);
      check($sformatf("v%0d_active", i), ShellActive, vq[i].act);
      check($sformatf("v%0d_fired", i),  Fired,       vq[i].fired);
      check($sformatf("v%0d_x", i),      sx(0),       vq[i].x);
      check($sformatf("v%0d_y", i),      sy(0),       vq[i].y);
    end

    // Held key fires exactly once.
    do_reset();
    TankX = 10'd300; TankY = 10'd240; sin = 8'h00; cos = 8'h00;
    fire_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step(FK);
      if (Fired) fire_cnt++;
    end
    check("held_fire_count", fire_cnt, 1);
    check("held_active", ShellActive, 4'b0001);
    step(32'h0);

    // Cooldown: reject at +5 and +15, accept at +17 (no reload on reject) and +16 after that.
    do_reset();
    step(FK);
    check("cd_first_fired", Fired, 1'b1);
    for (int i = 1; i <= 4; i++) step(32'h0);
    step(FK);
    check("cd_f5_fired", Fired, 1'b0);
    check("cd_f5_active", ShellActive, 4'b0001);
    for (int i = 6; i <= 14; i++) step(32'h0);
    step(FK);
    check("cd_f15_fired", Fired, 1'b0);
    step(32'h0);
    step(FK);
    check("cd_f17_fired", Fired, 1'b1);
    check("cd_f17_active", ShellActive, 4'b0011);
    for (int i = 18; i <= 32; i++) step(32'h0);
    step(FK);
    check("cd_f33_fired", Fired, 1'b1);
    check("cd_f33_active", ShellActive, 4'b0111);

    // Slots full, expiry, same-edge expiry/press, and slot reuse.
    do_reset();
    TankX = 10'd300; TankY = 10'd240; sin = 8'h00; cos = 8'h00;
    for (int e = 0; e <= LIFE + 2; e++) begin
      if (e == LIFE + 2) begin TankX = 10'd111; TankY = 10'd222; end
      step((e == 0 || e == 20 || e == 40 || e == 60 || e == 80 || e == LIFE || e == LIFE + 2) ? FK : 32'h0);
      if (e == 60) begin
        check("full_active", ShellActive, 4'b1111);
        check("full_fired", Fired, 1'b1);
      end
      if (e == 80) begin
        check("fifth_fired", Fired, 1'b0);
        check("fifth_active", ShellActive, 4'b1111);
      end
      if (e == LIFE - 1) check("pre_expiry_active", ShellActive, 4'b1111);
      if (e == LIFE) begin
        check("expiry_active", ShellActive, 4'b1110);
        check("expiry_same_edge_fired", Fired, 1'b0);
        check("expiry_x_held", sx(0), 10'd300);
      end
      if (e == LIFE + 2) begin
        check("reuse_fired", Fired, 1'b1);
        check("reuse_active", ShellActive, 4'b1111);
        check("reuse_x", sx(0), 10'd111);
        check("reuse_y", sy(0), 10'd222);
      end
    end

    // Asynchronous reset mid-flight.
    do_reset();
    TankX = 10'd300; TankY = 10'd240; sin = 8'h00; cos = 8'h7F;
    for (int e = 0; e <= 40; e++) step((e == 0 || e == 20 || e == 40) ? FK : 32'h0);
    check("midflight_active", ShellActive, 4'b0111);
    keycode = '0;
    #2;
    Reset = 1'b1;
    #1;
    check("async_rst_active", ShellActive, 4'b0000);
    check("async_rst_x", ShellX, 40'd0);
    @(posedge frame_clk); #1;
    Reset = 1'b0;
    TankX = 10'd77; TankY = 10'd88;
    step(FK);
    check("post_rst_fired", Fired, 1'b1);
    check("post_rst_active", ShellActive, 4'b0001);
    check("post_rst_x", sx(0), 10'd77);
    step(32'h0);

`ifdef TANK_SHELL_BOUNCE_LIMIT_EN
    // Vertical shuttle from Y=1: reflections on frames 1, 123, 245, 367, 489.
    do_reset();
    TankX = 10'd300; TankY = 10'd1; sin = 8'h7F; cos = 8'h00;
    for (int e = 0; e <= 489; e++) begin
      step((e == 0) ? FK : 32'h0);
      if (e == 367) check("bounce4_active", ShellActive, 4'b0001);
      if (e == 488) check("bounce_pre5_active", ShellActive, 4'b0001);
      if (e == 489) begin
        check("bounce5_active", ShellActive, 4'b0000);
        check("bounce5_y", sy(0), 10'd1);
      end
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
